// File: rtl/fp_div_pkg.sv
// Shared constants for the FP_Div mantissa path.
// mant_div_dp and Mant_Div_Ctrl both read the step count from here so
// that both ends of the load/shift_en protocol agree on the division length.
package fp_div_pkg;

    localparam int MANT_W     = 24;          // mantissa width including hidden bit
    localparam int CNT_W      = 5;           // step counter width, 2**CNT_W > MANT_W
    localparam int HIDDEN_BIT = MANT_W - 1;  // position of the implicit leading one
    localparam int DIV_STEPS  = MANT_W;      // quotient bits produced per division

    typedef logic [MANT_W-1:0] mant_t;
    typedef logic [MANT_W:0]   prem_t;       // partial remainder, one guard bit
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t CNT_ZERO      = {CNT_W{1'b0}};
    localparam cnt_t CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam cnt_t DIV_STEPS_CNT = cnt_t'(DIV_STEPS);

    // True while a division has started but not yet produced all its bits.
    function automatic logic cnt_in_progress(input cnt_t cnt);
        return (cnt != CNT_ZERO) && (cnt < DIV_STEPS_CNT);
    endfunction

endpackage

// File: rtl/mant_div_step.sv
// One restoring radix-2 division step: compare, conditional subtract, shift.
// The shift drops the guard bit, which is always zero because the
// conditional difference is strictly smaller than the divisor.
module mant_div_step #(
    parameter int W = 24
) (
    input  logic [W:0]   r,
    input  logic [W-1:0] d,
    output logic         q_bit,
    output logic [W:0]   r_next
);

    logic [W:0] d_ext_s;
    logic [W:0] diff_s;

    assign d_ext_s = {1'b0, d};
    assign diff_s  = r - d_ext_s;

    // Pick the quotient bit and the next partial remainder.
    always_comb begin
        q_bit = (r >= d_ext_s);
        if (q_bit) begin
            r_next = diff_s << 1;
        end else begin
            r_next = r << 1;
        end
    end

endmodule

// File: rtl/mant_div_dp.sv
// Restoring radix-2 mantissa divider datapath for FP_Div.
// in_load captures the operands and performs step 0; each in_shift_en
// performs one more step until MANT_W quotient bits have been produced.
// Optional protocol checker: define MANT_DIV_PROTO_CHK_EN to enable
// out_proto_err; otherwise it is tied low and no checker logic exists.
module mant_div_dp
    import fp_div_pkg::*;
(
    input  logic              in_Clk,
    input  logic              in_Rst_N,
    input  logic              in_load,
    input  logic              in_shift_en,
    input  logic [MANT_W-1:0] in_dividend,
    input  logic [MANT_W-1:0] in_divisor,
    output logic [MANT_W-1:0] out_quotient,
    output logic              out_sticky,
    output logic              out_valid,
    output logic              out_proto_err
);

    prem_t rem_r;
    mant_t div_r;
    mant_t q_r;
    cnt_t  cnt_r;
    logic  valid_r;

    prem_t step_r_s;
    mant_t step_d_s;
    logic  step_bit_s;
    prem_t step_rem_s;
    mant_t step_q_s;
    cnt_t  cnt_next_s;
    logic  do_shift_s;

    // Feed the single step unit from the fresh operands on load, else from state.
    always_comb begin
        step_r_s = rem_r;
        step_d_s = div_r;
        if (in_load) begin
            step_r_s = {1'b0, in_dividend};
            step_d_s = in_divisor;
        end else begin
            step_r_s = rem_r;
            step_d_s = div_r;
        end
    end

    mant_div_step #(
        .W (MANT_W)
    ) u_step (
        .r      (step_r_s),
        .d      (step_d_s),
        .q_bit  (step_bit_s),
        .r_next (step_rem_s)
    );

    // A load starts the quotient from zero; otherwise bits shift in LSB-first.
    assign step_q_s   = in_load ? {{(MANT_W-1){1'b0}}, step_bit_s}
                                : {q_r[MANT_W-2:0], step_bit_s};
    assign cnt_next_s = cnt_r + CNT_ONE;
    assign do_shift_s = !in_load && in_shift_en && (cnt_r < DIV_STEPS_CNT);

    // Division state: load restarts, shift advances, otherwise everything holds.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            rem_r   <= {(MANT_W+1){1'b0}};
            div_r   <= {MANT_W{1'b0}};
            q_r     <= {MANT_W{1'b0}};
            cnt_r   <= CNT_ZERO;
            valid_r <= 1'b0;
        end else if (in_load) begin
            rem_r   <= step_rem_s;
            div_r   <= in_divisor;
            q_r     <= step_q_s;
            cnt_r   <= CNT_ONE;
            valid_r <= 1'b0;
        end else if (do_shift_s) begin
            rem_r   <= step_rem_s;
            q_r     <= step_q_s;
            cnt_r   <= cnt_next_s;
            valid_r <= (cnt_next_s == DIV_STEPS_CNT);
        end
    end

    assign out_quotient = q_r;
    assign out_sticky   = |rem_r;
    assign out_valid    = valid_r;

`ifdef MANT_DIV_PROTO_CHK_EN
    logic proto_viol_s;
    logic proto_err_r;

    // Flag gaps in the strobe train, shifts before any load, and extra steps.
    always_comb begin
        proto_viol_s = 1'b0;
        if (in_load) begin
            proto_viol_s = 1'b0;
        end else if (in_shift_en) begin
            proto_viol_s = (cnt_r == CNT_ZERO) || (cnt_r == DIV_STEPS_CNT);
        end else begin
            proto_viol_s = cnt_in_progress(cnt_r);
        end
    end

    // Sticky error flag, cleared only by reset or the next load.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            proto_err_r <= 1'b0;
        end else if (in_load) begin
            proto_err_r <= 1'b0;
        end else if (proto_viol_s) begin
            proto_err_r <= 1'b1;
        end
    end

    assign out_proto_err = proto_err_r;
`else
    assign out_proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mant_div_dp.sv
// Self-checking bench for mant_div_dp: a closed-form division model is
// compared against the outputs on every falling edge, plus directed cases
// with hand-computed results and randomized back-to-back divisions.
module tb_mant_div_dp;
    import fp_div_pkg::*;

    logic              in_Clk = 1'b0;
    logic              in_Rst_N;
    logic              in_load;
    logic              in_shift_en;
    logic [MANT_W-1:0] in_dividend;
    logic [MANT_W-1:0] in_divisor;
    logic [MANT_W-1:0] out_quotient;
    logic              out_sticky;
    logic              out_valid;
    logic              out_proto_err;

`ifdef MANT_DIV_PROTO_CHK_EN
    localparam logic PROTO_EXP = 1'b1;
`else
    localparam logic PROTO_EXP = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mant_div_dp dut (
        .in_Clk        (in_Clk),
        .in_Rst_N      (in_Rst_N),
        .in_load       (in_load),
        .in_shift_en   (in_shift_en),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .out_quotient  (out_quotient),
        .out_sticky    (out_sticky),
        .out_valid     (out_valid),
        .out_proto_err (out_proto_err)
    );

    always #5 in_Clk = ~in_Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Quotient after k steps: the top k bits of floor(a * 2^23 / b).
    function automatic logic [23:0] exp_q(input logic [23:0] a, input logic [23:0] b, input int k);
        logic [63:0] num;
        if (k == 0) return 24'h000000;
        if (b == 24'h000000) return 24'(((64'd1) << k) - 64'd1);
        num = {40'd0, a} << (k - 1);
        return 24'(num / {40'd0, b});
    endfunction

    // Remainder nonzero after k steps.
    function automatic logic exp_sticky(input logic [23:0] a, input logic [23:0] b, input int k);
        logic [63:0] num;
        if (k == 0) return (a != 24'h000000);
        if (b == 24'h000000) return ((({40'd0, a}) << k) & 64'h0000_0000_01FF_FFFF) != 64'd0;
        num = {40'd0, a} << (k - 1);
        return (num % {40'd0, b}) != 64'd0;
    endfunction

    // Model state: operands of the current division and how many steps it has taken.
    logic [23:0] m_a;
    logic [23:0] m_b;
    int          m_k;
    logic        m_err;

    always @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            m_a   <= 24'h000000;
            m_b   <= 24'h000000;
            m_k   <= 0;
            m_err <= 1'b0;
        end else begin
            if (in_load) begin
                m_a <= in_dividend;
                m_b <= in_divisor;
                m_k <= 1;
            end else if (in_shift_en && m_k < 24) begin
                m_k <= m_k + 1;
            end
`ifdef MANT_DIV_PROTO_CHK_EN
            if (in_load) m_err <= 1'b0;
            else if (in_shift_en && (m_k == 0 || m_k == 24)) m_err <= 1'b1;
            else if (!in_shift_en && m_k >= 1 && m_k <= 23) m_err <= 1'b1;
`endif
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge in_Clk) begin
        chk("cyc_valid",  64'(out_valid),     64'(m_k == 24));
        chk("cyc_q",      64'(out_quotient),  64'(exp_q(m_a, m_b, m_k)));
        chk("cyc_sticky", 64'(out_sticky),    64'(exp_sticky(m_a, m_b, m_k)));
        chk("cyc_perr",   64'(out_proto_err), 64'(m_err));
    end

    // Load then 23 shifts (+extra); rise = edges after the load edge where valid first seen.
    task automatic run_div(input logic [23:0] a, input logic [23:0] b, input int extra, output int rise);
        @(posedge in_Clk); #1;
        in_load     = 1'b1;
        in_shift_en = 1'($urandom_range(0, 1));
        in_dividend = a;
        in_divisor  = b;
        @(posedge in_Clk); #1;
        in_load     = 1'b0;
        in_shift_en = 1'b1;
        in_dividend = 24'($urandom);
        in_divisor  = 24'($urandom);
        rise = -1;
        for (int i = 1; i <= 23 + extra; i++) begin
            @(posedge in_Clk); #1;
            if (out_valid && rise < 0) rise = i;
            in_shift_en = (i < 23 + extra);
        end
    endtask

    // Load then n shifts, leaving in_shift_en high.
    task automatic partial(input logic [23:0] a, input logic [23:0] b, input int n);
        @(posedge in_Clk); #1;
        in_load     = 1'b1;
        in_shift_en = 1'b0;
        in_dividend = a;
        in_divisor  = b;
        @(posedge in_Clk); #1;
        in_load     = 1'b0;
        in_shift_en = 1'b1;
        repeat (n) @(posedge in_Clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise;
        logic [23:0] a;
        logic [23:0] b;
        in_Rst_N    = 1'b0;
        in_load     = 1'b0;
        in_shift_en = 1'b0;
        in_dividend = 24'h000000;
        in_divisor  = 24'h000000;
        repeat (3) @(posedge in_Clk);
        #1;
        chk("rst_q",     64'(out_quotient),  64'h0);
        chk("rst_stk",   64'(out_sticky),    64'h0);
        chk("rst_valid", 64'(out_valid),     64'h0);
        chk("rst_perr",  64'(out_proto_err), 64'h0);
        in_Rst_N = 1'b1;

        run_div(24'h800000, 24'h800000, 0, rise);
        chk("one_q",    64'(out_quotient), 64'h800000);
        chk("one_stk",  64'(out_sticky),   64'h0);
        chk("one_rise", 64'(rise),         64'd23);

        run_div(24'hC00000, 24'h800000, 0, rise);
        chk("c_8_q",   64'(out_quotient), 64'hC00000);
        chk("c_8_stk", 64'(out_sticky),   64'h0);

        run_div(24'h800000, 24'hC00000, 0, rise);
        chk("8_c_q",   64'(out_quotient), 64'h555555);
        chk("8_c_stk", 64'(out_sticky),   64'h1);

        // Gap in the strobe train at cnt=5.
        partial(24'h800000, 24'hC00000, 4);
        in_shift_en = 1'b0;
        @(posedge in_Clk); #1;
        chk("perr_gap", 64'(out_proto_err), 64'(PROTO_EXP));
        run_div(24'h800000, 24'hC00000, 0, rise);
        chk("perr_clr", 64'(out_proto_err), 64'h0);
        chk("gap_q",    64'(out_quotient),  64'h555555);

        // Divide by zero, then extra shifts after completion.
        run_div(24'h800000, 24'h000000, 5, rise);
        chk("dz_q",     64'(out_quotient),  64'hFFFFFF);
        chk("dz_stk",   64'(out_sticky),    64'h0);
        chk("dz_valid", 64'(out_valid),     64'h1);
        chk("dz_perr",  64'(out_proto_err), 64'(PROTO_EXP));

        // Restart mid-division.
        partial(24'hF00000, 24'h900000, 9);
        run_div(24'hC00000, 24'h800000, 0, rise);
        chk("rs_q",    64'(out_quotient), 64'hC00000);
        chk("rs_stk",  64'(out_sticky),   64'h0);
        chk("rs_rise", 64'(rise),         64'd23);

        // Asynchronous reset mid-division.
        partial(24'hC00000, 24'h800000, 6);
        #2;
        in_Rst_N = 1'b0;
        #1;
        chk("ar_q",     64'(out_quotient), 64'h0);
        chk("ar_stk",   64'(out_sticky),   64'h0);
        chk("ar_valid", 64'(out_valid),    64'h0);
        in_shift_en = 1'b0;
        @(posedge in_Clk); #1;
        in_Rst_N = 1'b1;
        repeat (30) @(posedge in_Clk);
        #1;
        chk("ar_novalid", 64'(out_valid), 64'h0);

        // Shift before any load.
        in_shift_en = 1'b1;
        @(posedge in_Clk); #1;
        in_shift_en = 1'b0;
        chk("perr_early", 64'(out_proto_err), 64'(PROTO_EXP));
        run_div(24'hA00000, 24'hE00000, 0, rise);
        chk("early_clr", 64'(out_proto_err), 64'h0);

        // Random normalised mantissas, back to back.
        for (int n = 0; n < 1000; n++) begin
            a = {1'b1, 23'($urandom)};
            b = {1'b1, 23'($urandom)};
            run_div(a, b, 0, rise);
            chk("rnd_q",    64'(out_quotient), 64'(exp_q(a, b, 24)));
            chk("rnd_stk",  64'(out_sticky),   64'(exp_sticky(a, b, 24)));
            chk("rnd_rise", 64'(rise),         64'd23);
        end

        @(posedge in_Clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mant_div_dp.md
Name: mant_div_dp

Overview:
- Restoring radix-2 mantissa divider datapath for the 32-bit FP divider (FP_Div).
- Receiving end of the Mant_Div_Ctrl load/shift_en protocol: samples the controller strobes and performs one quotient-bit step per strobed cycle.
- Produces the 24-bit quotient and a sticky bit, which feed FP_Div normalisation and rounding.
- Special operands (NaN, Inf, zero) are resolved upstream in FP_Div; this block only does the mantissa arithmetic.

Parameters:
- MANT_W, 24, mantissa width including hidden bit; also the number of quotient-bit steps.
- CNT_W, 5, step counter width; must satisfy 2^CNT_W > MANT_W.

Ports:
- in_Clk  input  1  clock; all state updates on rising edge.
- in_Rst_N  input  1  asynchronous, active-low reset.
- in_load  input  1  from controller: capture operands and perform step 0.
- in_shift_en  input  1  from controller: perform one division step.
- in_dividend  input  MANT_W  dividend mantissa {1,frac}; sampled only when in_load=1.
- in_divisor  input  MANT_W  divisor mantissa {1,frac}; sampled only when in_load=1.
- out_quotient  output  MANT_W  quotient, MSB = integer bit, shifted in LSB-first.
- out_sticky  output  1  1 when the final partial remainder is nonzero.
- out_valid  output  1  result complete; level signal.
- out_proto_err  output  1  protocol violation flag; see Optional Feature.

Behaviour:
- Registers:
  - rem: MANT_W+1 bits.
  - div: MANT_W bits.
  - q: MANT_W bits.
  - cnt: CNT_W bits.
  - valid: 1 bit.
- Reset: the asynchronous in_Rst_N=0 clears all registers immediately. All outputs are 0 during and after reset. Reset mid-division discards the operation; no valid is produced.
- Step function, given current partial remainder r and divisor d:
  - If r >= d: bit=1, r_next=(r-d)<<1.
  - Else: bit=0, r_next=r<<1.
  - Comparison and subtract are unsigned at MANT_W+1 bits. The shift drops the MSB, which is always 0 because r-d < d.
  - q_next={q[MANT_W-2:0],bit}.
- Load cycle (in_load=1):
  - div<=in_divisor.
  - Step applied with r={0,in_dividend} and q=0.
  - cnt<=1, valid<=0.
  - in_load has priority over in_shift_en; either value of in_shift_en gives the same result.
  - A load during an in-progress division restarts cleanly.
- Shift cycle (in_load=0, in_shift_en=1, cnt<MANT_W): step applied to rem/q; cnt<=cnt+1.
- When a step makes cnt==MANT_W: valid<=1 on the same edge.
- Once cnt==MANT_W: in_shift_en is ignored; rem, q and cnt hold.
- Idle cycle (both strobes 0): all registers hold.
- Latency:
  - Load at edge T gives MANT_W steps at edges T..T+MANT_W-1.
  - out_valid is high from edge T+MANT_W-1 until the next load or reset.
  - With the controller (load in state 1, shift_en in states 1..24), out_valid rises entering state 25, exactly when stall drops.
- Outputs: out_quotient=q; out_sticky=|rem; out_valid=valid. All are registered-derived with no combinational path from inputs.
- Divisor zero: every step takes bit=1, so out_quotient=all ones. FP_Div masks this case.

Optional Feature:
- Macro MANT_DIV_PROTO_CHK_EN.
- When defined, out_proto_err is set sticky (cleared only by reset or the next in_load) on any of:
  - in_shift_en=0 and in_load=0 while 0<cnt<MANT_W. The controller must strobe contiguously.
  - in_shift_en=1 with cnt==0 and in_load=0, i.e. a shift before any load.
  - in_shift_en=1 with cnt==MANT_W, i.e. an extra step.
- The arithmetic is unaffected by the checker.
- When not defined, out_proto_err is tied 0 and the checker logic is absent.

Decomposition:
- Shared package/header fp_div_pkg holds:
  - MANT_W=24.
  - CNT_W=5.
  - Hidden-bit position constant.
  - The step-count constant also used by Mant_Div_Ctrl, so both ends agree on length.
- One sub-module, mant_div_step: combinational compare/subtract/shift for a single step (r, d → bit, r_next). It is instantiated once and its input is muxed between load operands and registers.

Test Plan:
- Load 0x800000/0x800000, then 23 shifts → out_quotient=0x800000, out_sticky=0, out_valid rises exactly 23 edges after the load edge.
- 0xC00000/0x800000 → 0xC00000, sticky=0. Then 0x800000/0xC00000 → 0x555555, sticky=1.
- Divisor 0x000000, dividend 0x800000 → out_quotient=0xFFFFFF. Extra shift_en pulses after completion leave outputs unchanged.
- New in_load at step 10 of a division with 0xC00000/0x800000 → 0xC00000, with valid timed from the new load. Asserting in_Rst_N=0 mid-division clears all outputs asynchronously, and no valid appears afterwards.
- With MANT_DIV_PROTO_CHK_EN: dropping shift_en at cnt=5 → out_proto_err=1 next edge, cleared by the next load. Shift before any load → out_proto_err=1. Without the macro, out_proto_err stays 0 in all cases.
- Back-to-back operation with the real Mant_Div_Ctrl driven by in_start: random normalised mantissas over 1000 runs match a reference model for {quotient, sticky}.
